serial_mag_comp_ctrl: RTL and testbench

//   Bit-serial magnitude comparator controller. Latches two WIDTH-bit operands and

---
 rtl/serial_comp_pkg.sv | 27 ++
 rtl/serial_mag_comp_ctrl_if.sv | 27 ++
 rtl/bit_cmp_cell.sv | 12 +
 rtl/serial_mag_comp_ctrl.sv | 140 ++++++++++++++
 tb/tb_serial_mag_comp_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/serial_comp_pkg.sv
// Shared types and encodings for the bit-serial magnitude comparator.
package serial_comp_pkg;

  // State encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  // Compare result flags; exactly one bit is set for a valid result
  typedef struct packed {
    logic eq;
    logic gt;
    logic lt;
  } flags_t;

  localparam flags_t RES_NONE = 3'b000;
  localparam flags_t RES_EQ   = 3'b100;
  localparam flags_t RES_GT   = 3'b010;
  localparam flags_t RES_LT   = 3'b001;

endpackage

// File: rtl/serial_mag_comp_ctrl_if.sv
// Operand / result handshake bundle for serial_mag_comp_ctrl.
interface serial_mag_comp_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             res_valid;
  logic             res_ready;
  logic             eq;
  logic             gt;
  logic             lt;
  logic             busy;

  // Producer/consumer side
  modport master (
    output in_valid, a_in, b_in, res_ready,
    input  in_ready, res_valid, eq, gt, lt, busy
  );

  // Comparator side
  modport slave (
    input  in_valid, a_in, b_in, res_ready,
    output in_ready, res_valid, eq, gt, lt, busy
  );
endinterface

// File: rtl/bit_cmp_cell.sv
// Combinational 1-bit magnitude compare cell.
module bit_cmp_cell (
  input  logic a,
  input  logic b,
  output logic e,
  output logic g,
  output logic l
);
  assign e = ~(a ^ b);
  assign g = a & ~b;
  assign l = ~a & b;
endmodule

// File: rtl/serial_mag_comp_ctrl.sv
// Bit-serial magnitude comparator controller: latches two operands and walks a
// single 1-bit compare cell over them MSB first, one bit per clock.
// Optional macro SERIAL_COMP_EARLY_EXIT_EN: finish on the first differing bit.
module serial_mag_comp_ctrl
  import serial_comp_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  serial_mag_comp_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  flags_t             run_q, run_d;
  flags_t             res_q, res_d;
  logic               res_valid_q, res_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;

  logic               cell_e, cell_g, cell_l;
  flags_t             step_c;
  logic               last_c;

  // Shared compare cell looks at the current MSB of both shift registers
  bit_cmp_cell u_cell (
    .a (a_sh_q[WIDTH-1]),
    .b (b_sh_q[WIDTH-1]),
    .e (cell_e),
    .g (cell_g),
    .l (cell_l)
  );

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      idx_q       <= CNT_W'(WIDTH - 1);
      run_q       <= RES_EQ;
      res_q       <= RES_NONE;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      idx_q       <= idx_d;
      run_q       <= run_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state, sticky flag update and registered output values
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    idx_d       = idx_q;
    run_d       = run_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    in_ready_d  = in_ready_q;
    busy_d      = busy_q;
    last_c      = 1'b0;

    // The first differing bit decides the result; later bits are ignored
    step_c = run_q;
    if (run_q.eq && !cell_e) begin
      step_c.eq = 1'b0;
      step_c.gt = cell_g;
      step_c.lt = cell_l;
    end

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          state_d    = S_RUN;
          a_sh_d     = bus.a_in;
          b_sh_d     = bus.b_in;
          idx_d      = CNT_W'(WIDTH - 1);
          run_d      = RES_EQ;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      S_RUN: begin
        run_d  = step_c;
        a_sh_d = {a_sh_q[WIDTH-2:0], 1'b0};
        b_sh_d = {b_sh_q[WIDTH-2:0], 1'b0};
        idx_d  = idx_q - CNT_W'(1);
        last_c = (idx_q == '0);
`ifdef SERIAL_COMP_EARLY_EXIT_EN
        if (run_q.eq && !cell_e) begin
          last_c = 1'b1;
        end
`endif
        if (last_c) begin
          state_d     = S_DONE;
          res_d       = step_c;
          res_valid_d = 1'b1;
          idx_d       = CNT_W'(WIDTH - 1);
        end
      end

      S_DONE: begin
        if (bus.res_ready) begin
          state_d     = S_IDLE;
          res_d       = RES_NONE;
          res_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.eq        = res_q.eq;
  assign bus.gt        = res_q.gt;
  assign bus.lt        = res_q.lt;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_serial_mag_comp_ctrl.sv
// Directed-vector bench for serial_mag_comp_ctrl.
module tb_serial_mag_comp_ctrl;

  localparam int unsigned WIDTH = 8;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  serial_mag_comp_ctrl_if #(.WIDTH(WIDTH)) bus ();

  serial_mag_comp_ctrl #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected latency (edges from accept to res_valid, accept edge included)
  function automatic int exp_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x;
    int k;
    x = a ^ b;
    k = -1;
    for (int i = 0; i < int'(WIDTH); i++) if (x[i]) k = i;
`ifdef SERIAL_COMP_EARLY_EXIT_EN
    if (k >= 0) return (int'(WIDTH) - 1 - k) + 2;
`endif
    return int'(WIDTH) + 1;
  endfunction

  // Issue one operand pair, wait for the result and check it; consumer stays ready
  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [2:0] exp_flags, input int lat_exp);
    int lat;
    logic got;
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    bus.a_in     = a;
    bus.b_in     = b;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bus.res_valid) begin
        got = 1'b1;
        break;
      end
      tick();
      lat++;
    end
    check({tag, "_timeout"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(lat_exp));
    check({tag, "_flags"}, 64'({bus.eq, bus.gt, bus.lt}), 64'(exp_flags));
    check({tag, "_onehot"}, 64'($countones({bus.eq, bus.gt, bus.lt})), 64'd1);
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check({tag, "_drop"}, 64'({bus.res_valid, bus.eq, bus.gt, bus.lt}), 64'd0);
    check({tag, "_ready_back"}, 64'(bus.in_ready), 64'd1);
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic [2:0]       rf;
    logic             seen;
    n_vec = 0;
    n_err = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.res_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;

    // Reset values
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_outputs", 64'({bus.res_valid, bus.eq, bus.gt, bus.lt, bus.busy}), 64'd0);

    // Reset mid-RUN aborts the compare
    bus.a_in = 8'hF0; bus.b_in = 8'h0F; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    tick(); tick();
    check("mid_run_busy", 64'(bus.busy), 64'd1);
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_busy", 64'(bus.busy), 64'd0);
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (bus.res_valid || bus.busy) seen = 1'b1;
      tick();
    end
    check("abort_no_result", 64'(seen), 64'd0);

    // Directed cases
    run_op("equal", 8'hA5, 8'hA5, 3'b100, 9);
`ifdef SERIAL_COMP_EARLY_EXIT_EN
    run_op("msb_diff", 8'h80, 8'h7F, 3'b010, 2);
`else
    run_op("msb_diff", 8'h80, 8'h7F, 3'b010, 9);
`endif
    run_op("lsb_diff", 8'h10, 8'h11, 3'b001, 9);
    run_op("zeros", 8'h00, 8'h00, 3'b100, 9);
    run_op("ones", 8'hFF, 8'hFF, 3'b100, 9);

    // Backpressure with ignored in_valid pulses during RUN and DONE
    bus.a_in = 8'h03; bus.b_in = 8'h05; bus.in_valid = 1'b1;
    tick();
    bus.a_in = 8'hFF; bus.b_in = 8'h00;
    tick();
    check("bp_in_ready_run", 64'(bus.in_ready), 64'd0);
    bus.in_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (bus.res_valid) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    check("bp_timeout", 64'(seen), 64'd1);
    for (int c = 0; c < 5; c++) begin
      bus.in_valid = c[0];
      check("bp_hold", 64'({bus.res_valid, bus.eq, bus.gt, bus.lt, bus.busy, bus.in_ready}),
            64'(6'b100110));
      tick();
    end
    bus.in_valid  = 1'b0;
    bus.res_ready = 1'b1;
    tick();
    bus.res_ready = 1'b0;
    check("bp_release", 64'({bus.res_valid, bus.eq, bus.gt, bus.lt, bus.busy}), 64'd0);
    check("bp_in_ready_after", 64'(bus.in_ready), 64'd1);
    tick();
    check("bp_no_queued", 64'(bus.busy), 64'd0);

    // Random back-to-back pairs against a reference compare
    for (int n = 0; n < 16; n++) begin
      ra = WIDTH'($urandom);
      rb = (n % 4 == 0) ? ra : WIDTH'($urandom);
      rf = {ra == rb, ra > rb, ra < rb};
      run_op($sformatf("rand%0d", n), ra, rb, rf, exp_lat(ra, rb));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global guard against a hung run
  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1);
  end

endmodule
